rate_detector: RTL and testbench
================================

RATE_DETECTOR -- requirements
Module: rate_detector

Interface
REQ-001 Parameter P1, 50000000: nominal period in clock cycles for rate code 01.
REQ-002 Parameter P2, 100000000: nominal period for rate code 10.
REQ-003 Parameter P3, 200000000: nominal period for rate code 11.
REQ-004 Parameter TOL, 1000: allowed +/- deviation, in cycles, for classification.
REQ-005 Parameter TIMEOUT, 250000000: counter value that declares loss of input; must be > P3+TOL and < 2^28.
REQ-006 clock  input  1  system clock; all logic is on posedge clock.
REQ-007 reset_n  input  1  reset, synchronous, active-low.
REQ-008 pulse_in  input  1  tick stream already in the clock domain: one-cycle-high pulses, or held high for full rate.
REQ-009 period  output  28  cycles between the last two rising edges of pulse_in.
REQ-010 period_valid  output  1  one-cycle strobe; period was updated this cycle.
REQ-011 rate_code  output  2  classified rate: 00 full rate, 01 P1, 10 P2, 11 P3.
REQ-012 locked  output  1  high while the classification is stable.
REQ-013 timeout  output  1  level; no rising edge seen for TIMEOUT cycles.

Function
REQ-014 The block SHALL register pulse_in each cycle as pulse_d; rise = pulse_in & ~pulse_d.
REQ-015 The block SHALL keep a 3-bit saturating high-run counter: +1 when pulse_in=1, cleared when pulse_in=0.
REQ-016 The FSM SHALL have three states: SEARCH, MEASURE and STEADY; reset state is SEARCH.
REQ-017 In SEARCH, the first rise SHALL set cnt=1 and go to MEASURE; no period is reported.
REQ-018 In MEASURE, cnt SHALL increment by 1 every cycle without rise, and reload to 1 on rise.
REQ-019 On rise in MEASURE, the block SHALL set period=cnt and pulse period_valid for exactly one cycle; outputs are visible the cycle after the rising edge is sampled.
REQ-020 Period definition: rises sampled at cycles t0 and t1 SHALL give period = t1-t0.
REQ-021 Classification: period within [Pk-TOL, Pk+TOL] SHALL yield code k (01/10/11); otherwise the period is unclassified.
REQ-022 A classified period SHALL update rate_code.
REQ-023 locked SHALL be set when two consecutive classified periods yield the same code.
REQ-024 An unclassified period SHALL clear locked and leave rate_code unchanged.
REQ-025 A classified period whose code differs from the previous one SHALL update rate_code and clear locked.
REQ-026 In MEASURE, when cnt reaches TIMEOUT, the block SHALL set timeout=1, clear locked, go to SEARCH and hold rate_code.
REQ-027 timeout SHALL clear on the next rise in any state.
REQ-028 From SEARCH or MEASURE, a high-run count reaching 3 SHALL go to STEADY with rate_code=00, locked=1, timeout=0, and no period_valid.
REQ-029 In STEADY, pulse_in=0 SHALL go to SEARCH and clear locked; rate_code holds 00.
REQ-030 When rise and a timeout condition occur in the same cycle, rise SHALL win: the period is measured and timeout stays 0.
REQ-031 cnt SHALL never exceed TIMEOUT and never wrap.

Reset
REQ-032 When reset_n=0 at a posedge, the block SHALL set state=SEARCH and cnt, period, period_valid, rate_code, locked, timeout, pulse_d and the high-run counter to 0.
REQ-033 Reset SHALL take precedence over every other event.
REQ-034 Reset mid-measurement SHALL discard the partial count, so the first rise after reset only starts a measurement.

Verification (P1=10, P2=20, P3=40, TOL=1, TIMEOUT=60)
REQ-035 Pulses every 20 cycles -> no period_valid on first pulse; 2nd pulse gives period=20, rate_code=10, locked=0; 3rd pulse gives locked=1.
REQ-036 Pulses at spacing 10,10,40 -> rate_code 01 with locked=1, then rate_code 11 with locked=0 on the 40-cycle period.
REQ-037 Spacing 15 after lock at 10 -> period=15, period_valid=1, locked=0, rate_code stays 01.
REQ-038 Pulses stop after lock -> timeout=1 and locked=0 exactly 60 cycles after the last rise reload; the next pulse clears timeout and gives no period_valid.
REQ-039 pulse_in held high -> third consecutive high sample gives rate_code=00, locked=1; pulse_in dropping low gives locked=0.
REQ-040 reset_n low for 1 cycle mid-period -> all outputs 0 next cycle; the following rise gives no period_valid, and the rise after it gives the correct period.

Source files
------------

// File: rtl/rate_detector.sv
// rate_detector: measures the spacing of rising edges on pulse_in, classifies it into a rate code and tracks lock/loss
module rate_detector #(
  parameter int P1      = 50000000,
  parameter int P2      = 100000000,
  parameter int P3      = 200000000,
  parameter int TOL     = 1000,
  parameter int TIMEOUT = 250000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pulse_in,
  output logic [27:0] period,
  output logic        period_valid,
  output logic [1:0]  rate_code,
  output logic        locked,
  output logic        timeout
);
  localparam logic [27:0] P1_LO = 28'(P1 - TOL);
  localparam logic [27:0] P1_HI = 28'(P1 + TOL);
  localparam logic [27:0] P2_LO = 28'(P2 - TOL);
  localparam logic [27:0] P2_HI = 28'(P2 + TOL);
  localparam logic [27:0] P3_LO = 28'(P3 - TOL);
  localparam logic [27:0] P3_HI = 28'(P3 + TOL);
  localparam logic [27:0] TO    = 28'(TIMEOUT);
  typedef enum logic [1:0] {SEARCH, MEASURE, STEADY} state_t;
  state_t      state_q, state_d;
  logic [27:0] cnt_q, cnt_d, period_q, period_d;
  logic [2:0]  run_q, run_d;
  logic [1:0]  code_q, code_d, k;
  logic        pulse_prev_q, valid_q, valid_d, locked_q, locked_d;
  logic        timeout_q, timeout_d, prev_ok_q, prev_ok_d, rise, cls;
  // next-state: edge detect, high-run tracking, period measurement and classification
  always_comb begin
    rise      = pulse_in & ~pulse_prev_q;
    run_d     = pulse_in ? ((run_q == 3'd7) ? run_q : run_q + 3'd1) : 3'd0;
    k         = (cnt_q >= P1_LO && cnt_q <= P1_HI) ? 2'b01 :
                (cnt_q >= P2_LO && cnt_q <= P2_HI) ? 2'b10 :
                (cnt_q >= P3_LO && cnt_q <= P3_HI) ? 2'b11 : 2'b00;
    cls       = k != 2'b00;
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    code_d    = code_q;
    locked_d  = locked_q;
    timeout_d = rise ? 1'b0 : timeout_q;
    prev_ok_d = prev_ok_q;
    if (state_q != STEADY && run_d >= 3'd3) begin
      state_d   = STEADY;
      cnt_d     = '0;
      code_d    = 2'b00;
      locked_d  = 1'b1;
      timeout_d = 1'b0;
      prev_ok_d = 1'b0;
    end else if (state_q == STEADY) begin
      if (!pulse_in) begin
        state_d  = SEARCH;
        locked_d = 1'b0;
      end
    end else if (state_q == SEARCH) begin
      if (rise) begin
        state_d = MEASURE;
        cnt_d   = 28'd1;
      end
    end else if (rise) begin
      cnt_d     = 28'd1;
      period_d  = cnt_q;
      valid_d   = 1'b1;
      code_d    = cls ? k : code_q;
      locked_d  = cls && prev_ok_q && (k == code_q);
      prev_ok_d = cls;
    end else if (cnt_q == TO) begin
      state_d   = SEARCH;
      cnt_d     = '0;
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      prev_ok_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 28'd1;
    end
  end
  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      cnt_q        <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      code_q       <= 2'b00;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      prev_ok_q    <= 1'b0;
      pulse_prev_q <= 1'b0;
      run_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      code_q       <= code_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
      prev_ok_q    <= prev_ok_d;
      pulse_prev_q <= pulse_in;
      run_q        <= run_d;
    end
  end
  assign period       = period_q;
  assign period_valid = valid_q;
  assign rate_code    = code_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;
endmodule

// File: tb/tb_rate_detector.sv
// tb_rate_detector: directed scoreboard bench for rate_detector with small periods
module tb_rate_detector;
  logic        clock, reset_n, pulse_in;
  logic [27:0] period;
  logic        period_valid, locked, timeout;
  logic [1:0]  rate_code;
  typedef struct {logic [27:0] p; logic [1:0] c; logic l;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  rate_detector #(.P1(10), .P2(20), .P3(40), .TOL(1), .TIMEOUT(60)) dut (
    .clock(clock), .reset_n(reset_n), .pulse_in(pulse_in),
    .period(period), .period_valid(period_valid), .rate_code(rate_code),
    .locked(locked), .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input logic p);
    pulse_in = p;
    @(posedge clock);
    #1;
  endtask

  task automatic gap(input int s);
    repeat (s - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic gap_exp(input int s, input logic [1:0] c, input logic l);
    exp_t e;
    e.p = 28'(s);
    e.c = c;
    e.l = l;
    sb.push_back(e);
    gap(s);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_valid"}, 32'(period_valid), 0);
    check({tag, "_code"}, 32'(rate_code), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  always @(negedge clock) begin
    if (period_valid) begin
      if (sb.size() == 0) check("unexpected_valid", 32'(period_valid), 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_period", 32'(period), 32'(e.p));
        check("sb_code", 32'(rate_code), 32'(e.c));
        check("sb_locked", 32'(locked), 32'(e.l));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    pulse_in = 1'b0;
    repeat (3) step(1'b0);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (3) step(1'b0);
    step(1'b1);
    check("first_pulse_valid", 32'(period_valid), 0);
    gap_exp(20, 2'b10, 1'b0);
    gap_exp(20, 2'b10, 1'b1);
    check("lock20", 32'(locked), 1);
    gap_exp(10, 2'b01, 1'b0);
    gap_exp(10, 2'b01, 1'b1);
    gap_exp(40, 2'b11, 1'b0);
    gap_exp(10, 2'b01, 1'b0);
    gap_exp(10, 2'b01, 1'b1);
    gap_exp(15, 2'b01, 1'b0);
    check("unclass_code", 32'(rate_code), 1);
    gap_exp(10, 2'b01, 1'b0);
    gap_exp(10, 2'b01, 1'b1);
    repeat (59) step(1'b0);
    check("pre_timeout", 32'(timeout), 0);
    check("pre_timeout_locked", 32'(locked), 1);
    step(1'b0);
    check("timeout", 32'(timeout), 1);
    check("timeout_locked", 32'(locked), 0);
    check("timeout_code", 32'(rate_code), 1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("timeout_cleared", 32'(timeout), 0);
    check("after_timeout_valid", 32'(period_valid), 0);
    gap_exp(60, 2'b01, 1'b0);
    check("rise_beats_timeout", 32'(timeout), 0);
    step(1'b1);
    check("run2_locked", 32'(locked), 0);
    step(1'b1);
    check("steady_code", 32'(rate_code), 0);
    check("steady_locked", 32'(locked), 1);
    check("steady_valid", 32'(period_valid), 0);
    step(1'b1);
    step(1'b1);
    check("steady_hold", 32'(locked), 1);
    step(1'b0);
    check("steady_drop_locked", 32'(locked), 0);
    check("steady_drop_code", 32'(rate_code), 0);
    step(1'b1);
    repeat (5) step(1'b0);
    reset_n = 1'b0;
    step(1'b0);
    check_zero("midreset");
    reset_n = 1'b1;
    repeat (3) step(1'b0);
    step(1'b1);
    check("post_reset_first_valid", 32'(period_valid), 0);
    gap_exp(20, 2'b10, 1'b0);
    repeat (3) step(1'b0);
    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
